// File: rtl/dit_in_loader_if.sv
// Sample-stream and parallel-frame bus of the DIT FFT input loader.
// The loader uses the slave view; the upstream/downstream side uses master.
interface dit_in_loader_if #(
  parameter int unsigned DW = 3
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_re;
  logic [DW-1:0] s_im;
  logic          s_last;
  logic          frame_valid;
  logic          frame_ack;
  logic [DW-1:0] xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7;
  logic [DW-1:0] xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7;
  logic          sync_err;

  modport slave (
    input  s_valid, s_re, s_im, s_last, frame_ack,
    output s_ready, frame_valid, sync_err,
    output xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7,
    output xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7
  );

  modport master (
    output s_valid, s_re, s_im, s_last, frame_ack,
    input  s_ready, frame_valid, sync_err,
    input  xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7,
    input  xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7
  );
endinterface

// File: rtl/dit_in_loader.sv
// Ping-pong 8-sample frame assembler feeding the DIT FFT core.
// Define DIT_INBUF_BITREV_EN to store samples in bit-reversed slot order.
module dit_in_loader #(
  parameter int unsigned DW = 3
) (
  input  logic           clk,
  input  logic           rst,
  dit_in_loader_if.slave bus
);
  localparam int unsigned NS = 8;
  localparam int unsigned IW = 3;

  logic [DW-1:0] bank_re [2][NS];
  logic [DW-1:0] bank_im [2][NS];

  logic [1:0]    full_q, full_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          sync_err_q, sync_err_d;
  logic [IW-1:0] slot_c;
  logic          ready_c;
  logic          accept_c;
  logic          ack_c;

  assign ready_c  = !full_q[wr_sel_q];
  assign accept_c = bus.s_valid && ready_c;
  assign ack_c    = bus.frame_ack && full_q[rd_sel_q];

`ifdef DIT_INBUF_BITREV_EN
  assign slot_c = {wr_idx_q[0], wr_idx_q[1], wr_idx_q[2]};
`else
  assign slot_c = wr_idx_q;
`endif

  // Pointer/flag next state: completion sets the write bank, ack clears the read bank.
  always_comb begin
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    wr_idx_d   = wr_idx_q;
    sync_err_d = 1'b0;

    if (ack_c) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end

    if (accept_c) begin
      if (wr_idx_q == IW'(NS - 1)) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
        wr_idx_d         = '0;
        sync_err_d       = !bus.s_last;
      end else if (bus.s_last) begin
        wr_idx_d   = '0;
        sync_err_d = 1'b1;
      end else begin
        wr_idx_d = IW'(wr_idx_q + IW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      wr_idx_q   <= '0;
      sync_err_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      wr_idx_q   <= wr_idx_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Sample storage; a full bank is never written because s_ready is low for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(NS); i++) begin
          bank_re[b][i] <= '0;
          bank_im[b][i] <= '0;
        end
      end
    end else if (accept_c) begin
      bank_re[wr_sel_q][slot_c] <= bus.s_re;
      bank_im[wr_sel_q][slot_c] <= bus.s_im;
    end
  end

  assign bus.s_ready     = ready_c;
  assign bus.frame_valid = full_q[rd_sel_q];
  assign bus.sync_err    = sync_err_q;

  assign bus.xr0 = bank_re[rd_sel_q][0];
  assign bus.xr1 = bank_re[rd_sel_q][1];
  assign bus.xr2 = bank_re[rd_sel_q][2];
  assign bus.xr3 = bank_re[rd_sel_q][3];
  assign bus.xr4 = bank_re[rd_sel_q][4];
  assign bus.xr5 = bank_re[rd_sel_q][5];
  assign bus.xr6 = bank_re[rd_sel_q][6];
  assign bus.xr7 = bank_re[rd_sel_q][7];
  assign bus.xi0 = bank_im[rd_sel_q][0];
  assign bus.xi1 = bank_im[rd_sel_q][1];
  assign bus.xi2 = bank_im[rd_sel_q][2];
  assign bus.xi3 = bank_im[rd_sel_q][3];
  assign bus.xi4 = bank_im[rd_sel_q][4];
  assign bus.xi5 = bank_im[rd_sel_q][5];
  assign bus.xi6 = bank_im[rd_sel_q][6];
  assign bus.xi7 = bank_im[rd_sel_q][7];
endmodule

// File: tb/tb_dit_in_loader.sv
// Bench for dit_in_loader: directed scenarios plus random traffic against a frame-queue model.
// Honours DIT_INBUF_BITREV_EN to pick the expected output ordering.
module tb_dit_in_loader;
  localparam int unsigned DW = 3;

  typedef logic [DW-1:0] frame_t [8];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;

  dit_in_loader_if #(.DW(DW)) bus ();

  dit_in_loader #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] xr_a [8];
  logic [DW-1:0] xi_a [8];
  assign xr_a[0] = bus.xr0; assign xr_a[1] = bus.xr1; assign xr_a[2] = bus.xr2; assign xr_a[3] = bus.xr3;
  assign xr_a[4] = bus.xr4; assign xr_a[5] = bus.xr5; assign xr_a[6] = bus.xr6; assign xr_a[7] = bus.xr7;
  assign xi_a[0] = bus.xi0; assign xi_a[1] = bus.xi1; assign xi_a[2] = bus.xi2; assign xi_a[3] = bus.xi3;
  assign xi_a[4] = bus.xi4; assign xi_a[5] = bus.xi5; assign xi_a[6] = bus.xi6; assign xi_a[7] = bus.xi7;

  // Reference model: queue of completed frames (natural sample order) plus the partial frame.
  frame_t        fq_re[$];
  frame_t        fq_im[$];
  logic [DW-1:0] p_re[$];
  logic [DW-1:0] p_im[$];
  bit            exp_sync = 1'b0;
  bit            zero_out = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int out_src(input int k);
    logic [2:0] i;
    i = 3'(k);
`ifdef DIT_INBUF_BITREV_EN
    return int'({i[0], i[1], i[2]});
`else
    return int'(i);
`endif
  endfunction

  task automatic check_outputs();
    check("s_ready", 32'(bus.s_ready), 32'(fq_re.size() < 2));
    check("frame_valid", 32'(bus.frame_valid), 32'(fq_re.size() > 0));
    check("sync_err", 32'(bus.sync_err), 32'(exp_sync));
    for (int k = 0; k < 8; k++) begin
      if (fq_re.size() > 0) begin
        check($sformatf("xr%0d", k), 32'(xr_a[k]), 32'(fq_re[0][out_src(k)]));
        check($sformatf("xi%0d", k), 32'(xi_a[k]), 32'(fq_im[0][out_src(k)]));
      end else if (zero_out) begin
        check($sformatf("xr%0d_zero", k), 32'(xr_a[k]), 32'd0);
        check($sformatf("xi%0d_zero", k), 32'(xi_a[k]), 32'd0);
      end
    end
  endtask

  task automatic model_update(input bit r, input bit v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                              input bit last, input bit ack);
    bit     ready;
    bit     valid;
    frame_t f_re;
    frame_t f_im;
    if (r) begin
      fq_re.delete(); fq_im.delete(); p_re.delete(); p_im.delete();
      exp_sync = 1'b0;
      zero_out = 1'b1;
      return;
    end
    ready    = fq_re.size() < 2;
    valid    = fq_re.size() > 0;
    exp_sync = 1'b0;
    if (ack && valid) begin
      void'(fq_re.pop_front());
      void'(fq_im.pop_front());
    end
    if (v && ready) begin
      zero_out = 1'b0;
      p_re.push_back(re);
      p_im.push_back(im);
      if (p_re.size() == 8) begin
        for (int i = 0; i < 8; i++) begin
          f_re[i] = p_re[i];
          f_im[i] = p_im[i];
        end
        fq_re.push_back(f_re);
        fq_im.push_back(f_im);
        p_re.delete(); p_im.delete();
        exp_sync = !last;
      end else if (last) begin
        p_re.delete(); p_im.delete();
        exp_sync = 1'b1;
      end
    end
  endtask

  // One clock: check state left by the previous edge, drive inputs, advance the model.
  task automatic step(input bit r, input bit v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                      input bit last, input bit ack);
    @(negedge clk);
    if (started) check_outputs();
    rst           = r;
    bus.s_valid   = v;
    bus.s_re      = re;
    bus.s_im      = im;
    bus.s_last    = last;
    bus.frame_ack = ack;
    model_update(r, v, re, im, last, ack);
    if (r) started = 1'b1;
  endtask

  task automatic idle(input bit ack);
    step(1'b0, 1'b0, '0, '0, 1'b0, ack);
  endtask

  task automatic drain();
    for (int g = 0; g < 4 && fq_re.size() > 0; g++) idle(1'b1);
  endtask

  logic [DW-1:0] pat_a [8];
  logic [DW-1:0] pat_b [8];

  initial begin
    bus.s_valid = 1'b0; bus.s_re = '0; bus.s_im = '0; bus.s_last = 1'b0; bus.frame_ack = 1'b0;
    pat_a = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
    pat_b = '{3'd4, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0};

    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(1'b0);

    // Ramp frame, no ack.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), '0, i == 7, 1'b0);
    idle(1'b0);
    idle(1'b0);
    drain();

    // Two frames back-to-back, then stall on both banks full.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, pat_a[i], 3'(i), i == 7, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, pat_b[i], 3'(7 - i), i == 7, 1'b0);
    step(1'b0, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    drain();

    // Early last on the 5th sample, then a good frame.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'(i + 2), 3'(i), i == 4, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(7 - i), 3'(i), i == 7, 1'b0);
    idle(1'b0);
    drain();

    // Missing last: frame still completes.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i * 3), 3'(i + 1), 1'b0, 1'b0);
    idle(1'b0);

    // Ack the pending frame on the same edge the other bank completes.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i ^ 5), 3'(i ^ 2), i == 7, i == 7);
    idle(1'b0);
    idle(1'b0);

    // Reset with one full bank pending and a partial frame in flight.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd6, 3'd6, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i + 1), 3'(6 - i), i == 7, 1'b0);
    idle(1'b0);
    drain();

    // Random traffic with occasional frame-sync errors.
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      bit last;
      r    = $urandom_range(0, 99);
      last = (p_re.size() == 7) ? (r >= 6) : (r < 4);
      step(1'b0, $urandom_range(0, 99) < 75, DW'($urandom), DW'($urandom), last,
           $urandom_range(0, 99) < 30);
    end
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
